// File: rtl/keypad_emulator_if.sv
// Request/handshake and scanner-facing bundle of the keypad emulator.
// master = press source and row scanner, slave = emulator.
`timescale 1ns/1ps
interface keypad_emulator_if;
   logic        press_valid;
   logic        press_ready;
   logic [3:0]  key;
   logic [15:0] hold_cycles;
   logic [7:0]  bounce_cycles;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic        busy;
   logic        done;

   modport master (
      output press_valid, key, hold_cycles, bounce_cycles, rows,
      input  press_ready, cols, busy, done
   );

   modport slave (
      input  press_valid, key, hold_cycles, bounce_cycles, rows,
      output press_ready, cols, busy, done
   );
endinterface

// File: rtl/keypad_emulator.sv
// Emulates one 4x4 keypad press (bounce, hold, bounce) per accepted request; cols follow rows combinationally.
// Requests are accepted only in IDLE (press_ready); press_valid while busy is dropped, never queued.
`timescale 1ns/1ps
module keypad_emulator #(
   parameter logic [7:0] LFSR_SEED = 8'hB4,
   parameter bit         BOUNCE_EN = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   keypad_emulator_if.slave kp_if
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PBOUNCE,
      S_HOLD,
      S_RBOUNCE,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [3:0]  key;
      logic [15:0] hold;
      logic [7:0]  bounce;
   } req_t;

   state_e      state_q, state_d;
   req_t        req_q, req_d;
   logic [15:0] cnt_q, cnt_d;
   logic        contact_q, contact_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [1:0]  key_row, key_col;
   logic [3:0]  cols_w;

   function automatic logic [15:0] at_least_one(input logic [15:0] h);
      return (h == 16'd0) ? 16'd1 : h;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         req_q     <= '0;
         cnt_q     <= '0;
         contact_q <= 1'b0;
         lfsr_q    <= LFSR_SEED;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         cnt_q     <= cnt_d;
         contact_q <= contact_d;
         lfsr_q    <= lfsr_d;
      end
   end

   // cnt_q holds the cycles left in the current timed state, including this one.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (kp_if.press_valid) begin
               req_d = '{key: kp_if.key, hold: kp_if.hold_cycles, bounce: kp_if.bounce_cycles};
               if (BOUNCE_EN && (kp_if.bounce_cycles != 8'd0)) begin
                  state_d = S_PBOUNCE;
                  cnt_d   = {8'd0, kp_if.bounce_cycles};
               end else begin
                  state_d = S_HOLD;
                  cnt_d   = at_least_one(kp_if.hold_cycles);
               end
            end
         end
         S_PBOUNCE: begin
            if (cnt_q == 16'd1) begin
               state_d = S_HOLD;
               cnt_d   = at_least_one(req_q.hold);
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == 16'd1) begin
               if (BOUNCE_EN && (req_q.bounce != 8'd0)) begin
                  state_d = S_RBOUNCE;
                  cnt_d   = {8'd0, req_q.bounce};
               end else begin
                  state_d = S_DONE;
                  cnt_d   = 16'd0;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_RBOUNCE: begin
            if (cnt_q == 16'd1) begin
               state_d = S_DONE;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // Contact is registered against the next state so that during a bounce cycle it equals lfsr_q[0].
   always_comb begin
      lfsr_d = lfsr_q;
      if ((state_q == S_PBOUNCE) || (state_q == S_RBOUNCE)) begin
         lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
      contact_d = 1'b0;
      if (state_d == S_HOLD) begin
         contact_d = 1'b1;
      end else if ((state_d == S_PBOUNCE) || (state_d == S_RBOUNCE)) begin
         contact_d = lfsr_d[0];
      end
   end

   always_comb begin
      key_row = 2'd0;
      key_col = 2'd0;
      case (req_q.key)
         4'h1: begin key_row = 2'd0; key_col = 2'd0; end
         4'h2: begin key_row = 2'd0; key_col = 2'd1; end
         4'h3: begin key_row = 2'd0; key_col = 2'd2; end
         4'hA: begin key_row = 2'd0; key_col = 2'd3; end
         4'h4: begin key_row = 2'd1; key_col = 2'd0; end
         4'h5: begin key_row = 2'd1; key_col = 2'd1; end
         4'h6: begin key_row = 2'd1; key_col = 2'd2; end
         4'hB: begin key_row = 2'd1; key_col = 2'd3; end
         4'h7: begin key_row = 2'd2; key_col = 2'd0; end
         4'h8: begin key_row = 2'd2; key_col = 2'd1; end
         4'h9: begin key_row = 2'd2; key_col = 2'd2; end
         4'hC: begin key_row = 2'd2; key_col = 2'd3; end
         4'hE: begin key_row = 2'd3; key_col = 2'd0; end
         4'h0: begin key_row = 2'd3; key_col = 2'd1; end
         4'hF: begin key_row = 2'd3; key_col = 2'd2; end
         4'hD: begin key_row = 2'd3; key_col = 2'd3; end
         default: begin key_row = 2'd0; key_col = 2'd0; end
      endcase
   end

   always_comb begin
      cols_w          = 4'b0000;
      cols_w[key_col] = contact_q & kp_if.rows[key_row];
   end

   assign kp_if.cols        = cols_w;
   assign kp_if.press_ready = (state_q == S_IDLE);
   assign kp_if.busy        = (state_q != S_IDLE);
   assign kp_if.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench: per-cycle check against a phase-queue model of the press sequence, plus literal tallies.
`timescale 1ns/1ps
module tb_keypad_emulator;
   localparam logic [7:0] SEED = 8'hB4;
   localparam int PH_PB = 1, PH_HOLD = 2, PH_RB = 3, PH_DONE = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   keypad_emulator_if kp ();
   keypad_emulator_if kp2 ();

   keypad_emulator #(.LFSR_SEED(SEED), .BOUNCE_EN(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .kp_if(kp)
   );
   keypad_emulator #(.LFSR_SEED(SEED), .BOUNCE_EN(1'b0)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .kp_if(kp2)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Keypad layout as printed on the part: keymap[row][col].
   logic [3:0] keymap [0:3][0:3] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic [3:0] col_mask(input logic [3:0] k, input logic [3:0] r);
      logic [3:0] m;
      m = 4'b0000;
      for (int ri = 0; ri < 4; ri++)
         for (int ci = 0; ci < 4; ci++)
            if (keymap[ri][ci] == k && r[ri]) m[ci] = 1'b1;
      return m;
   endfunction

   // Model: one queue entry per remaining busy cycle; front entry is the current cycle.
   int         phq[$];
   logic [3:0] key_m = 4'h0;
   logic [7:0] lfsr_m = SEED;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phq.delete();
         key_m  = 4'h0;
         lfsr_m = SEED;
      end else if (phq.size() != 0) begin
         if (phq[0] == PH_PB || phq[0] == PH_RB)
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
         void'(phq.pop_front());
      end else if (kp.press_valid) begin
         int h;
         key_m = kp.key;
         h = (kp.hold_cycles == 16'd0) ? 1 : int'(kp.hold_cycles);
         for (int i = 0; i < int'(kp.bounce_cycles); i++) phq.push_back(PH_PB);
         for (int i = 0; i < h; i++) phq.push_back(PH_HOLD);
         for (int i = 0; i < int'(kp.bounce_cycles); i++) phq.push_back(PH_RB);
         phq.push_back(PH_DONE);
      end
   end

   int busy_tot = 0, done_tot = 0;
   int col_tot [4] = '{0, 0, 0, 0};
   int b2_busy_tot = 0, b2_done_tot = 0;
   int b2_col_tot [4] = '{0, 0, 0, 0};

   always @(negedge clk) begin
      int         ph;
      logic       contact;
      logic [3:0] exp_cols;
      ph = (phq.size() != 0) ? phq[0] : 0;
      contact = (ph == PH_HOLD) ? 1'b1 :
                ((ph == PH_PB) || (ph == PH_RB)) ? lfsr_m[0] : 1'b0;
      exp_cols = contact ? col_mask(key_m, kp.rows) : 4'b0000;
      check("cycle{ready,busy,done,cols}",
            {25'd0, kp.press_ready, kp.busy, kp.done, kp.cols},
            {25'd0, ph == 0, ph != 0, ph == PH_DONE, exp_cols});
      busy_tot += int'(kp.busy);
      done_tot += int'(kp.done);
      b2_busy_tot += int'(kp2.busy);
      b2_done_tot += int'(kp2.done);
      for (int c = 0; c < 4; c++) begin
         col_tot[c]    += int'(kp.cols[c]);
         b2_col_tot[c] += int'(kp2.cols[c]);
      end
   end

   int m_busy, m_done;
   int m_col [4];

   task automatic mark();
      m_busy = busy_tot;
      m_done = done_tot;
      for (int c = 0; c < 4; c++) m_col[c] = col_tot[c];
   endtask

   function automatic int dcol(input int c);
      return col_tot[c] - m_col[c];
   endfunction

   task automatic start_press(input logic [3:0] k, input logic [15:0] h, input logic [7:0] b);
      kp.press_valid   = 1'b1;
      kp.key           = k;
      kp.hold_cycles   = h;
      kp.bounce_cycles = b;
      @(posedge clk); #1;
      kp.press_valid   = 1'b0;
      kp.key           = ~k;
      kp.hold_cycles   = 16'h0003;
      kp.bounce_cycles = 8'h55;
   endtask

   task automatic wait_done(input int limit, input bit scan);
      int n;
      n = 0;
      while (n < limit) begin
         @(negedge clk);
         if (kp.done) break;
         @(posedge clk); #1;
         if (scan) kp.rows = {kp.rows[2:0], kp.rows[3]};
         n++;
      end
      check("done_seen", {31'd0, kp.done}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int n2;
      kp.press_valid = 1'b0; kp.key = 4'h0; kp.hold_cycles = 16'h0; kp.bounce_cycles = 8'h0; kp.rows = 4'h0;
      kp2.press_valid = 1'b0; kp2.key = 4'h0; kp2.hold_cycles = 16'h0; kp2.bounce_cycles = 8'h0; kp2.rows = 4'h0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cols", {28'd0, kp.cols}, 32'd0);
      check("rst_busy_done", {30'd0, kp.busy, kp.done}, 32'd0);
      rst_n = 1'b1;
      check("rst_ready", {31'd0, kp.press_ready}, 32'd1);

      // key 5, hold 10, no bounce, row 1 driven
      kp.rows = 4'b0010;
      mark();
      start_press(4'h5, 16'd10, 8'd0);
      wait_done(40, 1'b0);
      check("k5_col1_cycles", dcol(1), 32'd10);
      check("k5_other_cols", dcol(0) + dcol(2) + dcol(3), 32'd0);
      check("k5_busy", busy_tot - m_busy, 32'd11);
      check("k5_done", done_tot - m_done, 32'd1);

      // key D, hold 5, bounce 8, rows scanning one-hot
      kp.rows = 4'b0001;
      mark();
      start_press(4'hD, 16'd5, 8'd8);
      wait_done(60, 1'b1);
      check("kD_busy", busy_tot - m_busy, 32'd22);
      check("kD_off_cols", dcol(0) + dcol(1) + dcol(2), 32'd0);
      check("kD_done", done_tot - m_done, 32'd1);

      // bounce disabled instance: key 0, hold 3, bounce 20
      kp2.rows = 4'b1000;
      n2 = b2_busy_tot;
      for (int c = 0; c < 4; c++) m_col[c] = b2_col_tot[c];
      m_done = b2_done_tot;
      kp2.press_valid = 1'b1; kp2.key = 4'h0; kp2.hold_cycles = 16'd3; kp2.bounce_cycles = 8'd20;
      @(posedge clk); #1;
      kp2.press_valid = 1'b0; kp2.key = 4'h7; kp2.bounce_cycles = 8'd9;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (kp2.done) break;
         @(posedge clk); #1;
      end
      check("nb_done_seen", {31'd0, kp2.done}, 32'd1);
      @(posedge clk); #1;
      check("nb_busy", b2_busy_tot - n2, 32'd4);
      check("nb_col1", b2_col_tot[1] - m_col[1], 32'd3);
      check("nb_other_cols", (b2_col_tot[0] - m_col[0]) + (b2_col_tot[2] - m_col[2]) + (b2_col_tot[3] - m_col[3]), 32'd0);
      check("nb_done", b2_done_tot - m_done, 32'd1);

      // second request during HOLD is dropped
      kp.rows = 4'b0010;
      mark();
      start_press(4'h6, 16'd8, 8'd2);
      repeat (3) begin @(posedge clk); #1; end
      kp.press_valid = 1'b1; kp.key = 4'h1; kp.hold_cycles = 16'd2; kp.bounce_cycles = 8'd0;
      check("busy_ready_low", {31'd0, kp.press_ready}, 32'd0);
      repeat (3) begin @(posedge clk); #1; end
      kp.press_valid = 1'b0;
      wait_done(40, 1'b0);
      check("k6_busy", busy_tot - m_busy, 32'd13);
      check("k6_done", done_tot - m_done, 32'd1);

      // several rows driven together
      kp.rows = 4'b1110;
      mark();
      start_press(4'h8, 16'd4, 8'd0);
      wait_done(20, 1'b0);
      check("multi_row_hit", dcol(1), 32'd4);
      kp.rows = 4'b1101;
      mark();
      start_press(4'h6, 16'd4, 8'd0);
      wait_done(20, 1'b0);
      check("multi_row_miss", dcol(0) + dcol(1) + dcol(2) + dcol(3), 32'd0);

      // hold 0 behaves as 1; no row driven gives no contact
      kp.rows = 4'b0001;
      mark();
      start_press(4'h1, 16'd0, 8'd0);
      wait_done(10, 1'b0);
      check("h0_col0", dcol(0), 32'd1);
      check("h0_busy", busy_tot - m_busy, 32'd2);
      kp.rows = 4'b0000;
      mark();
      start_press(4'h1, 16'd0, 8'd0);
      wait_done(10, 1'b0);
      check("norow_cols", dcol(0) + dcol(1) + dcol(2) + dcol(3), 32'd0);

      // one-cycle reset in the middle of HOLD
      kp.rows = 4'b0001;
      start_press(4'hA, 16'd20, 8'd0);
      repeat (4) begin @(posedge clk); #1; end
      check("kA_pre_reset_cols", {28'd0, kp.cols}, 32'h8);
      mark();
      rst_n = 1'b0;
      #1;
      check("kA_reset_cols", {28'd0, kp.cols}, 32'd0);
      check("kA_reset_busy", {31'd0, kp.busy}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("kA_ready_after", {31'd0, kp.press_ready}, 32'd1);
      check("kA_no_done", done_tot - m_done, 32'd0);
      start_press(4'h3, 16'd2, 8'd1);
      wait_done(20, 1'b0);

      // bounce on both sides with the LFSR continuing from the previous press
      kp.rows = 4'b0100;
      mark();
      start_press(4'h9, 16'd6, 8'd5);
      wait_done(40, 1'b0);
      check("k9_busy", busy_tot - m_busy, 32'd17);

      // longest hold
      kp.rows = 4'b0010;
      mark();
      start_press(4'h5, 16'hFFFF, 8'd0);
      wait_done(70000, 1'b0);
      check("long_col1", dcol(1), 32'd65535);
      check("long_busy", busy_tot - m_busy, 32'd65536);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
